row_sequencer: RTL and testbench

Controller that sequences the `multiplier` dot-product engine across every output row of the fully connected classifier layer. On `start` it issues `begin_mult` once per row with `row_select` held stable, and waits for `done_row`. Each `row_result` is captured into an internal result file, and a running signed argmax is tracked. On completion it reports the winning class index. It sits between the top-level control FSM and `multiplier`, and owns `row_select`/`begin_mult` exclusively.

---
 rtl/mlp_pkg.sv | 15 +
 rtl/argmax_tracker.sv | 32 +++
 rtl/row_sequencer.sv | 131 +++++++++++++
 tb/tb_row_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared sizes and state encoding for the classifier-layer control path
// (row_sequencer, multiplier and the top-level FSM).
package mlp_pkg;
  localparam int NUM_ROWS_DEF = 10;
  localparam int ROW_W_DEF    = 4;
  localparam int DATA_W_DEF   = 16;
  localparam int TIMEOUT_DEF  = 1023;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } seq_state_e;
endpackage

// File: rtl/argmax_tracker.sv
// Running signed argmax over the rows of one run; the lowest index wins ties.
module argmax_tracker
  import mlp_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load_first,
  input  logic              valid,
  input  logic [ROW_W-1:0]  idx,
  input  logic [DATA_W-1:0] value,
  output logic [ROW_W-1:0]  class_idx,
  output logic [DATA_W-1:0] max_value
);
  logic better;

  // Strict compare keeps the earlier row on equal values.
  assign better = load_first || ($signed(value) > $signed(max_value));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      class_idx <= '0;
      max_value <= '0;
    end else if (valid && better) begin
      class_idx <= idx;
      max_value <= value;
    end
  end
endmodule

// File: rtl/row_sequencer.sv
// Launches the multiplier once per output row, captures each row result and
// reports the winning class index of the run.
module row_sequencer
  import mlp_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int ROW_W    = ROW_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              done_row,
  input  logic [DATA_W-1:0] row_result,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [ROW_W-1:0]  row_select,
  output logic              begin_mult,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROW_W-1:0]  class_idx,
  output logic [DATA_W-1:0] max_value,
  output logic [DATA_W-1:0] rd_data
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  seq_state_e        state;
  logic [ROW_W-1:0]  row_cnt;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] res [NUM_ROWS];
  logic              accept, capture, last_row;

  assign accept     = (state == IDLE) && start;
  assign capture    = (state == WAIT) && done_row && !abort;
  assign last_row   = row_cnt == ROW_W'(NUM_ROWS - 1);
  assign row_select = row_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row_cnt    <= '0;
      timer      <= '0;
      begin_mult <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      begin_mult <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ISSUE;
            row_cnt    <= '0;
            timer      <= '0;
            error      <= 1'b0;
            begin_mult <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ISSUE: begin
          timer <= '0;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (done_row) begin
            if (last_row) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              row_cnt    <= row_cnt + ROW_W'(1);
              state      <= ISSUE;
              begin_mult <= 1'b1;
            end
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            // Multiplier never answered: end the run with the partial argmax.
            error <= 1'b1;
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Result file survives start; only rst clears it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (rst) res[i] <= '0;
      else if (capture && row_cnt == ROW_W'(i)) res[i] <= row_result;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_ROWS; i++)
      if (rd_row == ROW_W'(i)) rd_data = res[i];
  end

  argmax_tracker #(.ROW_W(ROW_W), .DATA_W(DATA_W)) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept),
    .load_first (row_cnt == '0),
    .valid      (capture),
    .idx        (row_cnt),
    .value      (row_result),
    .class_idx  (class_idx),
    .max_value  (max_value)
  );
endmodule

// File: tb/tb_row_sequencer.sv
// Bench for row_sequencer: behavioural multiplier plus a reference argmax and
// result-file model computed directly from the row data.
module tb_row_sequencer;
  localparam int NR = 10, RW = 4, DW = 16, TO = 20, W = 3;

  logic clk = 1'b0;
  logic rst, start, abort, done_row;
  logic [DW-1:0] row_result;
  logic [RW-1:0] rd_row;
  logic [RW-1:0] row_select, class_idx;
  logic begin_mult, busy, done, error;
  logic [DW-1:0] max_value, rd_data;

  row_sequencer #(.NUM_ROWS(NR), .ROW_W(RW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .done_row(done_row),
    .row_result(row_result), .rd_row(rd_row), .row_select(row_select),
    .begin_mult(begin_mult), .busy(busy), .done(done), .error(error),
    .class_idx(class_idx), .max_value(max_value), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  logic signed [DW-1:0] mdata [NR];
  logic signed [DW-1:0] ref_file [NR];
  int withhold = -1;
  bit stray = 1'b0;
  int bm_rows[$];
  int done_cnt = 0, done_cyc = 0, start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor of launch pulses and completion pulses.
  initial forever begin
    @(negedge clk);
    if (begin_mult === 1'b1) bm_rows.push_back(int'(row_select));
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
  end

  // Behavioural multiplier: answers W cycles after begin_mult.
  initial begin
    int cnt, row;
    cnt = 0; row = 0; done_row = 1'b0; row_result = '0;
    forever begin
      @(posedge clk); #1;
      done_row = 1'b0;
      if (stray) begin
        done_row = 1'b1; row_result = 16'd1234;
      end else if (begin_mult === 1'b1) begin
        cnt = W; row = int'(row_select);
      end else if (busy !== 1'b1) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && row != withhold) begin
          done_row = 1'b1; row_result = mdata[row];
          vectors++;
          if (row_select !== RW'(row)) begin
            miscompares++;
            $display("FAIL row_select_stable: got %0d want %0d", row_select, row);
          end
        end
      end
    end
  end

  function automatic void model_argmax(input int n, output int idx, output logic signed [DW-1:0] mx);
    idx = 0;
    for (int i = 1; i < n; i++) if (mdata[i] > mdata[idx]) idx = i;
    mx = (n > 0) ? mdata[idx] : '0;
  endfunction

  function automatic void commit_file(input int n);
    for (int i = 0; i < n; i++) ref_file[i] = mdata[i];
  endfunction

  task automatic do_start();
    @(posedge clk); #1;
    bm_rows.delete(); done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(output bit ok);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    ok = done_cnt > 0;
  endtask

  task automatic check_file(input string name);
    for (int r = 0; r < 16; r++) begin
      logic [DW-1:0] exp;
      rd_row = RW'(r); #1;
      exp = (r < NR) ? ref_file[r] : '0;
      vectors++;
      if (rd_data !== exp) begin
        miscompares++;
        $display("FAIL %s rd_data[%0d]: got %h want %h", name, r, rd_data, exp);
      end
    end
  endtask

  task automatic check_run(input string name, input int nrows, input bit exp_err, input int exp_done);
    int eidx; logic signed [DW-1:0] emx; bit ok;
    wait_done(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL %s done_timeout: got 0 want 1", name); end
    model_argmax(nrows, eidx, emx);
    vectors += 5;
    if (done_cyc - start_cyc + 1 != exp_done) begin
      miscompares++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc - start_cyc + 1, exp_done);
    end
    if (class_idx !== RW'(eidx)) begin
      miscompares++; $display("FAIL %s class_idx: got %0d want %0d", name, class_idx, eidx);
    end
    if (max_value !== emx) begin
      miscompares++; $display("FAIL %s max_value: got %0d want %0d", name, $signed(max_value), emx);
    end
    if (error !== exp_err) begin
      miscompares++; $display("FAIL %s error: got %b want %b", name, error, exp_err);
    end
    if (bm_rows.size() != (exp_err ? nrows + 1 : nrows)) begin
      miscompares++; $display("FAIL %s begin_mult_count: got %0d want %0d", name, bm_rows.size(), exp_err ? nrows + 1 : nrows);
    end
    for (int i = 0; i < bm_rows.size(); i++) begin
      vectors++;
      if (bm_rows[i] != i) begin
        miscompares++; $display("FAIL %s row_order[%0d]: got %0d want %0d", name, i, bm_rows[i], i);
      end
    end
    commit_file(nrows);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; rd_row = '0;
    for (int i = 0; i < NR; i++) begin mdata[i] = '0; ref_file[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if ({row_select, begin_mult, busy, done, error, class_idx, max_value} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got sel=%0d bm=%b busy=%b done=%b err=%b cls=%0d max=%0d want all 0",
               row_select, begin_mult, busy, done, error, class_idx, max_value);
    end
    check_file("reset");
  endtask

  task automatic test_known();
    int v[NR] = '{5, 12, -3, 40, 7, 40, 0, -100, 1, 2};
    for (int i = 0; i < NR; i++) mdata[i] = DW'(v[i]);
    do_start();
    check_run("known", NR, 1'b0, NR * (1 + W) + 1);
    vectors += 2;
    if (class_idx !== 4'd3) begin miscompares++; $display("FAIL known_tie: got %0d want 3", class_idx); end
    rd_row = 4'd7; #1;
    if (rd_data !== 16'hFF9C) begin miscompares++; $display("FAIL known_rd7: got %h want ff9c", rd_data); end
    check_file("known");
  endtask

  task automatic test_negative();
    for (int i = 0; i < NR; i++) mdata[i] = DW'(-50 + i);
    do_start();
    check_run("negative", NR, 1'b0, NR * (1 + W) + 1);
    check_file("negative");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NR; i++)
        mdata[i] = (k[0]) ? DW'($urandom) : DW'(int'($urandom_range(0, 12)) - 6);
      do_start();
      check_run("random", NR, 1'b0, NR * (1 + W) + 1);
      check_file("random");
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < NR; i++) mdata[i] = DW'($urandom);
    withhold = 4;
    do_start();
    check_run("timeout", 4, 1'b1, 4 * (1 + W) + TO + 2);
    vectors++;
    if (row_select !== 4'd4) begin miscompares++; $display("FAIL timeout_row_select: got %0d want 4", row_select); end
    repeat (10) @(negedge clk);
    vectors++;
    if (bm_rows.size() != 5) begin miscompares++; $display("FAIL timeout_extra_launch: got %0d want 5", bm_rows.size()); end
    withhold = -1;
    check_file("timeout");
  endtask

  task automatic test_abort();
    for (int i = 0; i < NR; i++) mdata[i] = DW'($urandom);
    do_start();
    for (int i = 0; i < 200 && bm_rows.size() < 3; i++) @(negedge clk);
    vectors++;
    if (bm_rows.size() < 3) begin miscompares++; $display("FAIL abort_reach_row2: got %0d want 3", bm_rows.size()); end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    if (begin_mult !== 1'b0) begin miscompares++; $display("FAIL abort_begin_mult: got %b want 0", begin_mult); end
    repeat (12) @(negedge clk);
    vectors += 2;
    if (done_cnt != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
    if (bm_rows.size() != 3) begin miscompares++; $display("FAIL abort_no_relaunch: got %0d want 3", bm_rows.size()); end
    commit_file(2);
    check_file("abort");
    for (int i = 0; i < NR; i++) mdata[i] = DW'($urandom);
    do_start();
    check_run("after_abort", NR, 1'b0, NR * (1 + W) + 1);
    check_file("after_abort");
  endtask

  task automatic test_rst_midrun();
    for (int i = 0; i < NR; i++) mdata[i] = DW'($urandom);
    do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 200 && bm_rows.size() < 7; i++) @(negedge clk);
    vectors++;
    if (bm_rows.size() != 7) begin miscompares++; $display("FAIL rst_reach_row6: got %0d want 7", bm_rows.size()); end
    for (int i = 0; i < bm_rows.size(); i++) begin
      vectors++;
      if (bm_rows[i] != i) begin miscompares++; $display("FAIL busy_start_order[%0d]: got %0d want %0d", i, bm_rows[i], i); end
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bm_rows.delete();
    for (int i = 0; i < NR; i++) ref_file[i] = '0;
    vectors++;
    if ({row_select, begin_mult, busy, done, error, class_idx, max_value} !== '0) begin
      miscompares++;
      $display("FAIL rst_midrun_outputs: got sel=%0d bm=%b busy=%b done=%b err=%b cls=%0d max=%0d want all 0",
               row_select, begin_mult, busy, done, error, class_idx, max_value);
    end
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    repeat (4) @(negedge clk);
    vectors += 3;
    if (busy !== 1'b0 || bm_rows.size() != 0) begin
      miscompares++; $display("FAIL stray_idle: got busy=%b launches=%0d want 0 0", busy, bm_rows.size());
    end
    if (class_idx !== '0 || max_value !== '0) begin
      miscompares++; $display("FAIL stray_argmax: got cls=%0d max=%0d want 0 0", class_idx, max_value);
    end
    if (done_cnt != 0) begin miscompares++; $display("FAIL rst_no_done: got %0d want 0", done_cnt); end
    check_file("stray");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NR; i++) mdata[i] = DW'(int'($urandom_range(1, 500)));
    withhold = 2;
    do_start();
    check_run("b2b_first", 2, 1'b1, 2 * (1 + W) + TO + 2);
    withhold = -1;
    for (int i = 0; i < NR; i++) mdata[i] = DW'($urandom);
    do_start();
    vectors += 2;
    if (error !== 1'b0) begin miscompares++; $display("FAIL b2b_error_clear: got %b want 0", error); end
    if (class_idx !== '0 || max_value !== '0) begin
      miscompares++; $display("FAIL b2b_argmax_clear: got cls=%0d max=%0d want 0 0", class_idx, max_value);
    end
    check_run("b2b_second", NR, 1'b0, NR * (1 + W) + 1);
    check_file("b2b");
  endtask

  initial begin
    test_reset();
    test_known();
    test_negative();
    test_random();
    test_timeout();
    test_abort();
    test_rst_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
